therm_seq_monitor: RTL and testbench
====================================

// Module: therm_seq_monitor
// PURPOSE
//  Receive-side checker for the 8-phase thermometer sequencer bus (00,01,03,07,0F,1F,3F,7F).
//  Samples the bus every clk_trl edge, decodes it to a 3-bit phase index and checks the step order.
//  Declares lock after a run of correct steps and counts completed 7->0 cycles.
//  Flags illegal codes and sequence breaks for the calendar control logic.
// PARAMETERS
//  LOCK_N      4   consecutive good steps needed to go HUNT->LOCKED (1..15)
//  ALLOW_HOLD  0   1: a repeated identical phase is tolerated; 0: a repeat is a sequence error
//  CNT_W       16  width of cycle_cnt
// PORTS
//  clk_trl      in   1      clock, all logic on rising edge
//  reset        in   1      synchronous, active-high; highest priority
//  state_in     in   8      thermometer bus from the sequencer
//  phase        out  3      decoded phase of last legal sample (0..7)
//  phase_valid  out  1      last sample was a legal code
//  locked       out  1      FSM in LOCKED
//  wrap_pulse   out  1      1-cycle pulse on a legal 7->0 step taken while LOCKED
//  cycle_cnt    out  CNT_W  count of wrap_pulse events; wraps modulo 2^CNT_W
//  err_illegal  out  1      1-cycle pulse: sample not one of the 8 legal codes
//  err_seq      out  1      1-cycle pulse: legal code but not prev+1 mod 8
//  err_cnt      out  8      total errors (illegal + seq), saturates at 255
// BEHAVIOUR
//  Interface: reset reset, synchronous, active-high; clock clk_trl.
//  - Reset: phase=0, phase_valid=0, locked=0, wrap_pulse=0, cycle_cnt=0, err_illegal=0,
//    err_seq=0, err_cnt=0; internal prev_valid=0, run_cnt=0, FSM=HUNT.
//  - All outputs registered; each reflects the state_in sampled on the same edge (1-cycle latency).
//  - Decode: 00->0, 01->1, 03->2, 07->3, 0F->4, 1F->5, 3F->6, 7F->7; any other value (incl. FF) illegal.
//  - Per edge, the sample is classified with this priority:
//    ILLEGAL: err_illegal=1, phase_valid=0, phase holds, prev_valid<=0.
//    FIRST: legal and prev_valid=0. No step check, no error. Load prev and set prev_valid<=1.
//    GOOD: legal and phase==prev+1 mod 8.
//    HOLD: legal and phase==prev, with ALLOW_HOLD=1. No error and run_cnt unchanged.
//    SEQ: any other legal case (including a repeat with ALLOW_HOLD=0). err_seq=1.
//    An illegal sample never also raises err_seq.
//    Every legal sample updates phase, sets phase_valid=1 and updates prev.
//  - FSM HUNT: GOOD increments run_cnt. When run_cnt reaches LOCK_N, go to LOCKED and clear run_cnt.
//    locked=1 on that same edge.
//    ILLEGAL or SEQ clears run_cnt. FIRST leaves run_cnt at 0.
//  - FSM LOCKED: ILLEGAL or SEQ -> HUNT, locked=0 on that edge, run_cnt=0.
//    GOOD/HOLD stay in LOCKED.
//  - wrap_pulse=1 only on a GOOD 7->0 step while the FSM was LOCKED before the edge.
//    cycle_cnt+1 on the same edge. No wrap credit is given in HUNT.
//  - err_cnt +1 per errored sample (at most 1 per edge); holds at 255.
//  - A mid-operation reset returns everything to reset values on that edge.
//    The first sample after reset is FIRST.
// TESTING
//  1. LOCK_N=4, feed 00,01,03,07,0F,1F,3F,7F,00 repeating -> locked=1 on 4th GOOD edge (sample 0F);
//     wrap_pulse and cycle_cnt=1 at 7F->00.
//  2. While locked, inject 05 -> err_illegal 1 cycle, phase_valid=0, locked=0, err_cnt=1.
//     Resume with 07 (FIRST), then 0F,1F,3F,7F -> relock on the 7F edge.
//  3. While locked, step 03->0F -> err_seq=1, locked=0, phase=4, phase_valid=1, err_cnt+1.
//  4. Repeat 07,07: ALLOW_HOLD=0 -> err_seq on the 2nd 07. ALLOW_HOLD=1 -> no error, locked stays 1.
//  5. Drive FF for 300 edges -> err_illegal every edge, err_cnt=255 saturated, locked=0.
//  6. Assert reset while locked with cycle_cnt=5 -> next edge all outputs 0.
//     Then 3F,7F,00 -> no err on 3F, GOOD steps, no wrap_pulse (HUNT).

Source files
------------

// File: rtl/therm_seq_monitor.sv
// Receive-side checker for the 8-phase thermometer sequencer bus: decodes each
// sample to a phase index, checks the step order, tracks lock and counts completed cycles.
module therm_seq_monitor #(
  parameter int LOCK_N     = 4,
  parameter int ALLOW_HOLD = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_trl,
  input  logic             reset,
  input  logic [7:0]       state_in,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [7:0]       err_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;
  typedef enum logic [2:0] {C_ILLEGAL, C_FIRST, C_GOOD, C_HOLD, C_SEQ} cls_t;

  // Returns {legal, index}.
  function automatic logic [3:0] decode(input logic [7:0] code);
    case (code)
      8'h00:   return 4'b1_000;
      8'h01:   return 4'b1_001;
      8'h03:   return 4'b1_010;
      8'h07:   return 4'b1_011;
      8'h0F:   return 4'b1_100;
      8'h1F:   return 4'b1_101;
      8'h3F:   return 4'b1_110;
      8'h7F:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  state_t      state_q, state_d;
  cls_t        cls;
  logic [3:0]  dec;
  logic        legal;
  logic [2:0]  idx;
  logic [3:0]  run_cnt, run_d;
  logic        wrap_d;
  logic        is_err;

  // phase/phase_valid double as the previous-sample registers: phase holds on
  // an illegal sample and phase_valid drops exactly when the next sample must be FIRST.
  always_comb begin
    dec   = decode(state_in);
    legal = dec[3];
    idx   = dec[2:0];
    cls   = C_SEQ;
    if (!legal)                                   cls = C_ILLEGAL;
    else if (!phase_valid)                        cls = C_FIRST;
    else if (idx == phase + 3'd1)                 cls = C_GOOD;
    else if ((idx == phase) && (ALLOW_HOLD != 0)) cls = C_HOLD;
    else                                          cls = C_SEQ;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_cnt;
    is_err  = (cls == C_ILLEGAL) || (cls == C_SEQ);
    wrap_d  = (cls == C_GOOD) && (state_q == LOCKED) && (idx == 3'd0);
    case (state_q)
      HUNT: begin
        if (cls == C_GOOD) begin
          if ((run_cnt + 4'd1) == 4'(LOCK_N)) begin
            state_d = LOCKED;
            run_d   = 4'd0;
          end else begin
            run_d = run_cnt + 4'd1;
          end
        end else if (is_err) begin
          run_d = 4'd0;
        end
      end
      LOCKED: begin
        if (is_err) begin
          state_d = HUNT;
          run_d   = 4'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_trl) begin
    if (reset) begin
      state_q <= HUNT;
      run_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      run_cnt <= run_d;
    end
  end

  assign locked = (state_q == LOCKED);

  // Registered outputs: one-cycle latency from the sampled bus.
  always_ff @(posedge clk_trl) begin
    if (reset) begin
      phase       <= 3'd0;
      phase_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      cycle_cnt   <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      if (legal) phase <= idx;
      phase_valid <= legal;
      wrap_pulse  <= wrap_d;
      if (wrap_d) cycle_cnt <= cycle_cnt + CNT_W'(1);
      err_illegal <= (cls == C_ILLEGAL);
      err_seq     <= (cls == C_SEQ);
      err_cnt     <= sat_inc8(err_cnt, is_err);
    end
  end

endmodule

// File: tb/tb_therm_seq_monitor.sv
// Scoreboarded bench for therm_seq_monitor: two instances (repeat = error, repeat tolerated)
// share one stimulus; a behavioural model predicts every output on every edge.
module tb_therm_seq_monitor;

  logic        clk_trl = 1'b0;
  logic        reset;
  logic [7:0]  state_in;

  logic [2:0]  phase0, phase1;
  logic        pv0, pv1, locked0, locked1, wrap0, wrap1;
  logic [15:0] cyc0, cyc1;
  logic        ei0, ei1, es0, es1;
  logic [7:0]  ec0, ec1;

  int checks = 0;
  int failures = 0;

  always #5 clk_trl = ~clk_trl;

  therm_seq_monitor #(.LOCK_N(4), .ALLOW_HOLD(0), .CNT_W(16)) dut (
    .clk_trl(clk_trl), .reset(reset), .state_in(state_in),
    .phase(phase0), .phase_valid(pv0), .locked(locked0), .wrap_pulse(wrap0),
    .cycle_cnt(cyc0), .err_illegal(ei0), .err_seq(es0), .err_cnt(ec0));

  therm_seq_monitor #(.LOCK_N(4), .ALLOW_HOLD(1), .CNT_W(16)) dut_h (
    .clk_trl(clk_trl), .reset(reset), .state_in(state_in),
    .phase(phase1), .phase_valid(pv1), .locked(locked1), .wrap_pulse(wrap1),
    .cycle_cnt(cyc1), .err_illegal(ei1), .err_seq(es1), .err_cnt(ec1));

  logic [7:0] codes [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};

  // Reference model state, index 0 = no hold, 1 = hold tolerated.
  logic [2:0]  m_phase [2];
  logic        m_pv [2], m_lock [2], m_wrap [2], m_ei [2], m_es [2];
  int          m_run [2], m_ec [2];
  logic [15:0] m_cyc [2];

  logic [31:0] sb [$];

  task automatic model_step(input logic r, input logic [7:0] v, input int h);
    bit legal = 0;
    int idx = 0;
    if (r) begin
      m_phase[h] = 3'd0; m_pv[h] = 0; m_lock[h] = 0; m_wrap[h] = 0; m_ei[h] = 0;
      m_es[h] = 0; m_run[h] = 0; m_ec[h] = 0; m_cyc[h] = 16'd0;
      return;
    end
    for (int k = 0; k < 8; k++) if (codes[k] == v) begin legal = 1; idx = k; end
    m_wrap[h] = 0; m_ei[h] = 0; m_es[h] = 0;
    if (!legal) begin
      m_ei[h] = 1; m_pv[h] = 0; m_lock[h] = 0; m_run[h] = 0;
    end else if (!m_pv[h]) begin
      m_phase[h] = 3'(idx); m_pv[h] = 1;
    end else if (idx == (int'(m_phase[h]) + 1) % 8) begin
      if (m_lock[h]) begin
        if (idx == 0) begin m_wrap[h] = 1; m_cyc[h] = m_cyc[h] + 16'd1; end
      end else begin
        m_run[h]++;
        if (m_run[h] == 4) begin m_lock[h] = 1; m_run[h] = 0; end
      end
      m_phase[h] = 3'(idx);
    end else if (idx == int'(m_phase[h]) && h == 1) begin
      // tolerated repeat: nothing changes
    end else begin
      m_es[h] = 1; m_lock[h] = 0; m_run[h] = 0; m_phase[h] = 3'(idx);
    end
    if ((m_ei[h] || m_es[h]) && m_ec[h] < 255) m_ec[h]++;
  endtask

  // One edge: drive on the falling edge, predict, then compare both instances after the rising edge.
  task automatic cycle(input logic r, input logic [7:0] v);
    logic [31:0] e, a;
    @(negedge clk_trl);
    reset = r;
    state_in = v;
    for (int h = 0; h < 2; h++) begin
      model_step(r, v, h);
      sb.push_back({m_phase[h], m_pv[h], m_lock[h], m_wrap[h], m_cyc[h], m_ei[h], m_es[h], 8'(m_ec[h])});
    end
    @(posedge clk_trl);
    #1;
    for (int h = 0; h < 2; h++) begin
      e = sb.pop_front();
      a = (h == 0) ? {phase0, pv0, locked0, wrap0, cyc0, ei0, es0, ec0}
                   : {phase1, pv1, locked1, wrap1, cyc1, ei1, es1, ec1};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sb_hold%0d in=%h rst=%b actual=%h expected=%h", h, v, r, a, e);
      end
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'h00);
    checks++;
    if ({phase0, pv0, locked0, wrap0, cyc0, ei0, es0, ec0} !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0", {phase0, pv0, locked0, wrap0, cyc0, ei0, es0, ec0});
    end
  endtask

  task automatic test_lock();
    for (int k = 0; k < 4; k++) cycle(1'b0, codes[k]);
    checks++;
    if (locked0 !== 1'b0) begin failures++; $display("FAIL early_lock locked=%b required=0", locked0); end
    cycle(1'b0, 8'h0F);
    checks++;
    if (locked0 !== 1'b1) begin failures++; $display("FAIL lock_on_0F locked=%b required=1", locked0); end
    for (int k = 5; k < 8; k++) cycle(1'b0, codes[k]);
    cycle(1'b0, 8'h00);
    checks++;
    if ({wrap0, cyc0} !== {1'b1, 16'd1}) begin
      failures++; $display("FAIL first_wrap wrap=%b cnt=%0d required wrap=1 cnt=1", wrap0, cyc0);
    end
  endtask

  task automatic test_illegal();
    cycle(1'b0, 8'h01);
    cycle(1'b0, 8'h03);
    cycle(1'b0, 8'h05);
    checks++;
    if ({ei0, es0, pv0, locked0, ec0} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL illegal_05 ei=%b es=%b pv=%b locked=%b ec=%0d required 1 0 0 0 1", ei0, es0, pv0, locked0, ec0);
    end
    cycle(1'b0, 8'h07);
    checks++;
    if ({ei0, es0} !== 2'b00) begin failures++; $display("FAIL first_after_illegal err=%b%b required 00", ei0, es0); end
    cycle(1'b0, 8'h0F);
    cycle(1'b0, 8'h1F);
    cycle(1'b0, 8'h3F);
    checks++;
    if (locked0 !== 1'b0) begin failures++; $display("FAIL relock_early locked=%b required=0", locked0); end
    cycle(1'b0, 8'h7F);
    checks++;
    if (locked0 !== 1'b1) begin failures++; $display("FAIL relock_7F locked=%b required=1", locked0); end
  endtask

  task automatic test_seq();
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h01);
    cycle(1'b0, 8'h03);
    cycle(1'b0, 8'h0F);
    checks++;
    if ({es0, ei0, locked0, phase0, pv0, ec0} !== {1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL seq_break es=%b ei=%b locked=%b phase=%0d pv=%b ec=%0d required 1 0 0 4 1 2",
               es0, ei0, locked0, phase0, pv0, ec0);
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 8'h1F);
    cycle(1'b0, 8'h3F);
    cycle(1'b0, 8'h7F);
    cycle(1'b0, 8'h00);
    checks++;
    if ({locked0, wrap0, cyc0} !== {1'b1, 1'b0, 16'd2}) begin
      failures++; $display("FAIL lock_no_wrap locked=%b wrap=%b cnt=%0d required 1 0 2", locked0, wrap0, cyc0);
    end
    cycle(1'b0, 8'h01);
    cycle(1'b0, 8'h03);
    cycle(1'b0, 8'h07);
    cycle(1'b0, 8'h07);
    checks++;
    if ({es0, locked0, ec0} !== {1'b1, 1'b0, 8'd3}) begin
      failures++; $display("FAIL repeat_nohold es=%b locked=%b ec=%0d required 1 0 3", es0, locked0, ec0);
    end
    checks++;
    if ({es1, locked1, phase1, pv1} !== {1'b0, 1'b1, 3'd3, 1'b1}) begin
      failures++; $display("FAIL repeat_hold es=%b locked=%b phase=%0d pv=%b required 0 1 3 1", es1, locked1, phase1, pv1);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) cycle(1'b0, 8'hFF);
    checks++;
    if ({ei0, es0, ec0, locked0, ec1} !== {1'b1, 1'b0, 8'd255, 1'b0, 8'd255}) begin
      failures++;
      $display("FAIL saturate ei=%b es=%b ec=%0d locked=%b ec_hold=%0d required 1 0 255 0 255", ei0, es0, ec0, locked0, ec1);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'h00);
    for (int k = 0; k <= 40; k++) cycle(1'b0, codes[k % 8]);
    checks++;
    if ({locked0, cyc0} !== {1'b1, 16'd5}) begin
      failures++; $display("FAIL five_wraps locked=%b cnt=%0d required 1 5", locked0, cyc0);
    end
    cycle(1'b1, 8'h01);
    checks++;
    if ({phase0, pv0, locked0, wrap0, cyc0, ei0, es0, ec0} !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset actual=%h required=0", {phase0, pv0, locked0, wrap0, cyc0, ei0, es0, ec0});
    end
    cycle(1'b0, 8'h3F);
    checks++;
    if ({ei0, es0, pv0, phase0} !== {1'b0, 1'b0, 1'b1, 3'd6}) begin
      failures++; $display("FAIL first_3F ei=%b es=%b pv=%b phase=%0d required 0 0 1 6", ei0, es0, pv0, phase0);
    end
    cycle(1'b0, 8'h7F);
    cycle(1'b0, 8'h00);
    checks++;
    if ({wrap0, cyc0, es0, locked0} !== {1'b0, 16'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL hunt_no_wrap wrap=%b cnt=%0d es=%b locked=%b required 0 0 0 0", wrap0, cyc0, es0, locked0);
    end
  endtask

  initial begin
    reset = 1'b1;
    state_in = 8'h00;
    test_reset();
    test_lock();
    test_illegal();
    test_seq();
    test_hold();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
